// File: rtl/message_checker.sv
// Scans the 32-byte decrypted-message RAM and reports whether every byte is a
// lowercase letter or a space, stopping at the first illegal byte.
module message_checker (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_check,
  input  logic [7:0] dm_q,
  output logic [4:0] dm_address,
  output logic       check_done_flag,
  output logic       message_valid,
  output logic [4:0] bad_address,
  output logic [5:0] bytes_checked
);

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 6;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(31);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, CHECK, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt, bad_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              valid_nxt;
  logic              byte_legal;

  assign byte_legal = (dm_q == 8'h20) || ((dm_q >= 8'h61) && (dm_q <= 8'h7A));

  // Next-state and next-result logic; results hold unless a transition updates them.
  always_comb begin
    state_nxt = state;
    addr_nxt  = dm_address;
    bad_nxt   = bad_address;
    cnt_nxt   = bytes_checked;
    valid_nxt = message_valid;
    unique case (state)
      IDLE: begin
        if (start_check) begin
          state_nxt = ADDR;
          addr_nxt  = '0;
          bad_nxt   = '0;
          cnt_nxt   = '0;
          valid_nxt = 1'b0;
        end
      end
      ADDR:  state_nxt = WAIT;
      WAIT:  state_nxt = CHECK;
      CHECK: begin
        cnt_nxt = bytes_checked + CNT_W'(1);
        if (!byte_legal) begin
          state_nxt = DONE;
          bad_nxt   = dm_address;
          valid_nxt = 1'b0;
        end else if (dm_address == LAST_ADDR) begin
          state_nxt = DONE;
          bad_nxt   = '0;
          valid_nxt = 1'b1;
        end else begin
          state_nxt = ADDR;
          addr_nxt  = dm_address + ADDR_W'(1);
        end
      end
      DONE: begin
        if (!start_check) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      dm_address      <= '0;
      bad_address     <= '0;
      bytes_checked   <= '0;
      message_valid   <= 1'b0;
      check_done_flag <= 1'b0;
    end else begin
      state           <= state_nxt;
      dm_address      <= addr_nxt;
      bad_address     <= bad_nxt;
      bytes_checked   <= cnt_nxt;
      message_valid   <= valid_nxt;
      check_done_flag <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_message_checker.sv
// Directed bench for message_checker with a behavioural one-cycle-latency RAM.
module tb_message_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_check = 1'b0;
  logic [7:0] dm_q = 8'h00;
  logic [4:0] dm_address;
  logic       check_done_flag;
  logic       message_valid;
  logic [4:0] bad_address;
  logic [5:0] bytes_checked;

  logic [7:0] mem [32];
  int tests = 0;
  int fails = 0;

  message_checker dut (
    .clk(clk), .reset(reset), .start_check(start_check), .dm_q(dm_q),
    .dm_address(dm_address), .check_done_flag(check_done_flag),
    .message_valid(message_valid), .bad_address(bad_address),
    .bytes_checked(bytes_checked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) dm_q <= mem[dm_address];

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 32; i++) mem[i] = v;
  endtask

  task automatic load_fox();
    string s;
    s = "the quick brown fox jumps over a";
    for (int i = 0; i < 32; i++) mem[i] = s[i];
  endtask

  // Counts edges (first edge = index 0) until check_done_flag is seen; -1 on timeout.
  task automatic run_wait(input int max_edges, output int edge_done, output logic [4:0] max_a);
    edge_done = -1;
    max_a = '0;
    for (int k = 0; k < max_edges; k++) begin
      @(posedge clk); #1;
      if (dm_address > max_a) max_a = dm_address;
      if (check_done_flag) begin
        edge_done = k;
        break;
      end
    end
  endtask

  task automatic to_idle();
    @(negedge clk) start_check = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_check = 1'b0;
    fill(8'h61);
    repeat (2) @(posedge clk);
    #1;
    tests++; if (check_done_flag !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", check_done_flag); end
    tests++; if (message_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", message_valid); end
    tests++; if (dm_address !== 5'd0) begin fails++; $display("FAIL reset_addr: got %0d expected 0", dm_address); end
    tests++; if (bad_address !== 5'd0) begin fails++; $display("FAIL reset_bad: got %0d expected 0", bad_address); end
    tests++; if (bytes_checked !== 6'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", bytes_checked); end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_fox_and_done_hold();
    int e;
    logic [4:0] m;
    int held_bad;
    load_fox();
    @(negedge clk) start_check = 1'b1;
    run_wait(200, e, m);
    tests++; if (e !== 96) begin fails++; $display("FAIL fox_latency: got edge %0d expected 96", e); end
    tests++; if (message_valid !== 1'b1) begin fails++; $display("FAIL fox_valid: got %b expected 1", message_valid); end
    tests++; if (bad_address !== 5'd0) begin fails++; $display("FAIL fox_bad: got %0d expected 0", bad_address); end
    tests++; if (bytes_checked !== 6'd32) begin fails++; $display("FAIL fox_count: got %0d expected 32", bytes_checked); end
    held_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (check_done_flag !== 1'b1) held_bad++;
    end
    tests++; if (held_bad !== 0) begin fails++; $display("FAIL done_hold: got %0d cycles low expected 0", held_bad); end
    start_check = 1'b0;
    @(posedge clk); #1;
    tests++; if (check_done_flag !== 1'b0) begin fails++; $display("FAIL done_release: got %b expected 0", check_done_flag); end
    tests++; if (message_valid !== 1'b1) begin fails++; $display("FAIL idle_valid_kept: got %b expected 1", message_valid); end
    tests++; if (bytes_checked !== 6'd32) begin fails++; $display("FAIL idle_count_kept: got %0d expected 32", bytes_checked); end
    to_idle();
  endtask

  task automatic test_early_abort();
    int e;
    logic [4:0] m;
    fill(8'h61);
    mem[5] = 8'h7B;
    @(negedge clk) start_check = 1'b1;
    @(posedge clk); #1;
    start_check = 1'b0;
    run_wait(200, e, m);
    tests++; if (e + 1 !== 18) begin fails++; $display("FAIL abort_latency: got edge %0d expected 18", e + 1); end
    tests++; if (message_valid !== 1'b0) begin fails++; $display("FAIL abort_valid: got %b expected 0", message_valid); end
    tests++; if (bad_address !== 5'd5) begin fails++; $display("FAIL abort_bad: got %0d expected 5", bad_address); end
    tests++; if (bytes_checked !== 6'd6) begin fails++; $display("FAIL abort_count: got %0d expected 6", bytes_checked); end
    tests++; if (m !== 5'd5) begin fails++; $display("FAIL abort_max_addr: got %0d expected 5", m); end
    @(posedge clk); #1;
    tests++; if (check_done_flag !== 1'b0) begin fails++; $display("FAIL abort_to_idle: got %b expected 0", check_done_flag); end
    tests++; if (bad_address !== 5'd5) begin fails++; $display("FAIL abort_bad_kept: got %0d expected 5", bad_address); end
    to_idle();
  endtask

  task automatic test_boundary();
    int e;
    logic [4:0] m;
    fill(8'h61);
    mem[0] = 8'h60;
    @(negedge clk) start_check = 1'b1;
    run_wait(200, e, m);
    tests++; if (e !== 3) begin fails++; $display("FAIL b0_latency: got edge %0d expected 3", e); end
    tests++; if (message_valid !== 1'b0) begin fails++; $display("FAIL b0_valid: got %b expected 0", message_valid); end
    tests++; if (bad_address !== 5'd0) begin fails++; $display("FAIL b0_bad: got %0d expected 0", bad_address); end
    tests++; if (bytes_checked !== 6'd1) begin fails++; $display("FAIL b0_count: got %0d expected 1", bytes_checked); end
    to_idle();
    fill(8'h20);
    mem[31] = 8'h7A;
    @(negedge clk) start_check = 1'b1;
    run_wait(200, e, m);
    tests++; if (e !== 96) begin fails++; $display("FAIL b31_latency: got edge %0d expected 96", e); end
    tests++; if (message_valid !== 1'b1) begin fails++; $display("FAIL b31_valid: got %b expected 1", message_valid); end
    tests++; if (m !== 5'd31) begin fails++; $display("FAIL b31_max_addr: got %0d expected 31", m); end
    to_idle();
  endtask

  task automatic test_legality();
    logic [7:0] vals [8];
    logic       legal [8];
    int e;
    logic [4:0] m;
    vals  = '{8'h00, 8'h1F, 8'h20, 8'h21, 8'h60, 8'h61, 8'h7A, 8'h7B};
    legal = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      fill(8'h20);
      mem[7] = vals[i];
      @(negedge clk) start_check = 1'b1;
      run_wait(200, e, m);
      tests++;
      if (message_valid !== legal[i]) begin
        fails++; $display("FAIL legal_%h_valid: got %b expected %b", vals[i], message_valid, legal[i]);
      end
      tests++;
      if (legal[i] ? (bytes_checked !== 6'd32 || e !== 96) : (bad_address !== 5'd7 || bytes_checked !== 6'd8 || e !== 24)) begin
        fails++; $display("FAIL legal_%h_result: got bad=%0d count=%0d edge=%0d expected legal=%b", vals[i], bad_address, bytes_checked, e, legal[i]);
      end
      to_idle();
    end
  endtask

  task automatic test_reset_mid_run();
    int e;
    logic [4:0] m;
    load_fox();
    @(negedge clk) start_check = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    tests++; if (bytes_checked !== 6'd13) begin fails++; $display("FAIL mid_count_pre: got %0d expected 13", bytes_checked); end
    reset = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (check_done_flag !== 1'b0 || message_valid !== 1'b0 || dm_address !== 5'd0 ||
        bad_address !== 5'd0 || bytes_checked !== 6'd0) begin
      fails++; $display("FAIL mid_reset_zero: got done=%b valid=%b addr=%0d bad=%0d count=%0d expected all 0",
                        check_done_flag, message_valid, dm_address, bad_address, bytes_checked);
    end
    reset = 1'b0;
    run_wait(200, e, m);
    tests++; if (e !== 96) begin fails++; $display("FAIL restart_latency: got edge %0d expected 96", e); end
    tests++; if (message_valid !== 1'b1 || bytes_checked !== 6'd32) begin fails++; $display("FAIL restart_result: got valid=%b count=%0d expected 1/32", message_valid, bytes_checked); end
    to_idle();
  endtask

  initial begin
    fill(8'h00);
    test_reset();
    test_fox_and_done_hold();
    test_early_abort();
    test_boundary();
    test_legality();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
